hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage core. Issues per-stage enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves four hazard classes:
  - load-use stalls, which register forwarding cannot cover;
  - taken-branch flushes;
  - multi-cycle MDU (mul/div) occupancy of EX;
  - data-memory wait freezes.
- Keeps saturating stall and flush performance counters.

Parameters:
MDU_CYCLES, 4, total EX-stage cycles of an MDU op; legal range 2..16.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
id_rs1  in  4  ID-stage source register 1
id_rs2  in  4  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  4  EX-stage destination register
ex_mem_read  in  1  EX instruction is a load
ex_mdu_op  in  1  EX instruction is a mul/div
branch_taken  in  1  EX resolved a taken branch/jump
dmem_wait  in  1  data memory not ready this cycle
pc_en  out  1  PC load enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX clear to NOP
ex_mem_en  out  1  EX/MEM register enable
ex_mem_flush  out  1  EX/MEM clear to NOP
mem_wb_en  out  1  MEM/WB register enable
mdu_busy  out  1  FSM is in MDU_BUSY
stall_cycles  out  CNT_W  count of cycles with pc_en=0
flush_events  out  CNT_W  count of branch flushes

Behaviour:

Reset:
- FSM goes to RUN. MDU counter and both perf counters clear to 0.
- While rst=1, all enables are 0, all flushes are 0, and mdu_busy=0.

Default outputs (no hazard, RUN): all enables 1, all flushes 0.

FSM states:
- RUN: normal issue.
- MDU_BUSY: a mul/div op is held in EX.

Control outputs are combinational from state and inputs. Counters and state are registered.

Priority, highest first, evaluated every cycle:

1. dmem_wait=1 (freeze):
   - pc_en, if_id_en, id_ex_en, ex_mem_en and mem_wb_en all 0; all flushes 0.
   - FSM state and MDU counter hold.
   - stall_cycles increments.
2. MDU handling:
   - RUN with ex_mdu_op=1: pc_en, if_id_en and id_ex_en = 0; ex_mem_flush=1 (bubble to MEM). Load mdu_cnt = MDU_CYCLES-2 and go to MDU_BUSY.
   - MDU_BUSY with mdu_cnt!=0: same stall outputs; mdu_cnt decrements.
   - MDU_BUSY with mdu_cnt==0: default outputs (op advances); go to RUN.
   - In RUN, ex_mdu_op is honoured only on the first cycle the op sits in EX. The instruction advances on the MDU_BUSY exit cycle, so re-entry cannot occur.
   - Net effect: exactly MDU_CYCLES-1 stall cycles per MDU op, excluding freeze cycles.
3. branch_taken=1 (RUN only):
   - pc_en=1; if_id_flush=1, id_ex_flush=1.
   - flush_events increments.
   - Suppresses any load-use stall in the same cycle, because the ID instruction is wrong-path.
4. Load-use (RUN only):
   - Condition: ex_mem_read=1, ex_rd!=0, and (id_uses_rs1 with id_rs1==ex_rd, or id_uses_rs2 with id_rs2==ex_rd).
   - pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble; the forwarding path covers the next cycle.

Other rules:
- Register 0 never causes a hazard.
- stall_cycles increments on every cycle with pc_en=0 and rst=0.
- Both counters saturate at all-ones and never wrap.
- branch_taken and ex_mdu_op together: MDU wins. The branch is ignored, as that case is illegal from decode.
- Reset asserted mid-MDU_BUSY: state is immediately RUN, and the counter is cleared asynchronously.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0→1; defaults next cycle.
2. Load to r0: ex_rd=0, id_rs1=0, id_uses_rs1=1 → no stall; all enables 1.
3. MDU, MDU_CYCLES=4: ex_mdu_op held until advance → 3 stall cycles with ex_mem_flush=1 and mdu_busy high for cycles 2–3; cycle 4 all enables 1; stall_cycles=3.
4. Branch plus load-use in the same cycle → if_id_flush=1, id_ex_flush=1, pc_en=1, no stall; flush_events=1.
5. dmem_wait for 2 cycles in the middle of MDU_BUSY (mdu_cnt=1) → all enables 0 for both cycles; mdu_cnt holds at 1; total stall cycles for the op = 3+2=5.
6. rst pulsed while in MDU_BUSY → mdu_busy=0 immediately with no clock edge; both counters read 0; RUN defaults after release.

Source files
------------

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard sequencing with stall/flush counters
module hazard_controller #(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [3:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_mdu_op,
    input  logic             branch_taken,
    input  logic             dmem_wait,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_BUSY = 1'b1;

    // Remaining stall cycles after the entry cycle; fits MDU_CYCLES up to 16.
    localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 2);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [3:0] mdu_cnt;
    logic [3:0] mdu_cnt_nxt;
    logic       load_use;
    logic       branch_flush;

    // A load in EX feeding the ID instruction; r0 is hardwired and never hazards.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != 4'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

    // Combinational stage controls and next-state selection in priority order.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b1;
        branch_flush = 1'b0;
        state_nxt    = state;
        mdu_cnt_nxt  = mdu_cnt;

        if (rst) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (dmem_wait) begin
            // Whole pipeline frozen; FSM and MDU counter hold.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (state == ST_MDU_BUSY) begin
            if (mdu_cnt != 4'd0) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                mdu_cnt_nxt  = mdu_cnt - 4'd1;
            end else begin
                // Op leaves EX this cycle with default controls.
                state_nxt = ST_RUN;
            end
        end else if (ex_mdu_op) begin
            // First cycle of the op in EX; a simultaneous branch is ignored.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            mdu_cnt_nxt  = MDU_LOAD;
            state_nxt    = ST_MDU_BUSY;
        end else if (branch_taken) begin
            // ID instruction is wrong-path, so any load-use is moot.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            branch_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Status flag, forced low while reset is asserted.
    always_comb begin
        mdu_busy = (state == ST_MDU_BUSY) && !rst;
    end

    // FSM state and MDU countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            mdu_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (branch_flush && (flush_events != {CNT_W{1'b1}}))
                flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       id_rs1;
    logic [3:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [3:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_mdu_op;
    logic             branch_taken;
    logic             dmem_wait;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             ex_mem_flush;
    logic             mem_wb_en;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.MDU_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_mdu_op    (ex_mdu_op),
        .branch_taken (branch_taken),
        .dmem_wait    (dmem_wait),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_en    (mem_wb_en),
        .mdu_busy     (mdu_busy),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Controls packed as {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes}.
    task automatic chk_ctl(input string tag, input logic [7:0] expected);
        chk(tag, int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush}), int'(expected));
    endtask

    task automatic clr_inputs();
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 4'd0; ex_mem_read = 1'b0; ex_mdu_op = 1'b0;
        branch_taken = 1'b0; dmem_wait = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] CTL_DEF    = 8'b11111_000;
    localparam logic [7:0] CTL_ZERO   = 8'b00000_000;
    localparam logic [7:0] CTL_LU     = 8'b00111_010;
    localparam logic [7:0] CTL_MDU    = 8'b00011_001;
    localparam logic [7:0] CTL_BRANCH = 8'b11111_110;

    initial begin
        clr_inputs();
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk_ctl("reset_ctl", CTL_ZERO);
        chk("reset_busy", int'(mdu_busy), 0);
        chk("reset_stall", int'(stall_cycles), 0);
        chk("reset_flush", int'(flush_events), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_ctl("run_default", CTL_DEF);
        tick();
        chk("idle_stall", int'(stall_cycles), 0);

        // Load-use on rs2: one bubble
        ex_mem_read = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5; id_uses_rs2 = 1'b1;
        @(negedge clk);
        chk_ctl("lu_ctl", CTL_LU);
        tick();
        chk("lu_stall", int'(stall_cycles), 1);
        clr_inputs();
        @(negedge clk);
        chk_ctl("lu_after", CTL_DEF);
        tick();

        // Load to r0 and non-matching source: no stall
        ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs1 = 4'd0; id_uses_rs1 = 1'b1;
        @(negedge clk);
        chk_ctl("r0_ctl", CTL_DEF);
        tick();
        ex_rd = 4'd5; id_rs1 = 4'd6; id_rs2 = 4'd5; id_uses_rs2 = 1'b0;
        @(negedge clk);
        chk_ctl("nomatch_ctl", CTL_DEF);
        tick();
        chk("nostall_cnt", int'(stall_cycles), 1);
        clr_inputs();

        // MDU op, branch asserted alongside on entry is ignored
        ex_mdu_op = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        chk_ctl("mdu_c1", CTL_MDU);
        chk("mdu_c1_busy", int'(mdu_busy), 0);
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        chk_ctl("mdu_c2", CTL_MDU);
        chk("mdu_c2_busy", int'(mdu_busy), 1);
        tick();
        @(negedge clk);
        chk_ctl("mdu_c3", CTL_MDU);
        chk("mdu_c3_busy", int'(mdu_busy), 1);
        tick();
        @(negedge clk);
        chk_ctl("mdu_c4", CTL_DEF);
        tick();
        ex_mdu_op = 1'b0;
        chk("mdu_stall", int'(stall_cycles), 4);
        chk("mdu_noflush", int'(flush_events), 0);
        @(negedge clk);
        chk("mdu_done_busy", int'(mdu_busy), 0);
        chk_ctl("mdu_done_ctl", CTL_DEF);
        tick();

        // Branch with simultaneous load-use: flush wins, no stall
        branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 4'd7; id_rs1 = 4'd7; id_uses_rs1 = 1'b1;
        @(negedge clk);
        chk_ctl("br_ctl", CTL_BRANCH);
        tick();
        chk("br_flush", int'(flush_events), 1);
        chk("br_stall", int'(stall_cycles), 4);
        clr_inputs();

        // Freeze for two cycles while mdu_cnt is 1
        ex_mdu_op = 1'b1;
        tick();
        @(negedge clk);
        chk_ctl("fz_busy_ctl", CTL_MDU);
        tick();
        dmem_wait = 1'b1;
        @(negedge clk);
        chk_ctl("fz_c1", CTL_ZERO);
        chk("fz_c1_busy", int'(mdu_busy), 1);
        tick();
        @(negedge clk);
        chk_ctl("fz_c2", CTL_ZERO);
        tick();
        dmem_wait = 1'b0;
        @(negedge clk);
        chk_ctl("fz_resume", CTL_MDU);
        tick();
        @(negedge clk);
        chk_ctl("fz_exit", CTL_DEF);
        tick();
        ex_mdu_op = 1'b0;
        chk("fz_stall", int'(stall_cycles), 9);

        // Freeze overrides a branch: no flush counted
        dmem_wait = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        chk_ctl("fz_br_ctl", CTL_ZERO);
        tick();
        chk("fz_br_flush", int'(flush_events), 1);
        chk("fz_br_stall", int'(stall_cycles), 10);
        clr_inputs();

        // Asynchronous reset in MDU_BUSY
        ex_mdu_op = 1'b1;
        tick();
        @(negedge clk);
        chk("ar_busy", int'(mdu_busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_busy_low", int'(mdu_busy), 0);
        chk_ctl("ar_ctl", CTL_ZERO);
        chk("ar_stall", int'(stall_cycles), 0);
        chk("ar_flush", int'(flush_events), 0);
        tick();
        rst = 1'b0;
        ex_mdu_op = 1'b0;
        @(negedge clk);
        chk_ctl("ar_release", CTL_DEF);
        chk("ar_release_busy", int'(mdu_busy), 0);
        tick();

        // Counter saturation
        dmem_wait = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", int'(stall_cycles), 15);
        dmem_wait = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_flush", int'(flush_events), 15);
        chk("sat_stall_hold", int'(stall_cycles), 15);
        clr_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
